// File: rtl/decode_stage.sv
// decode_stage: IF/ID pipeline register with RV32I decoder and post-redirect squash.
// Optional RV32M multiply recognition is enabled by defining DECODE_MUL_EN.
module decode_stage #(
    parameter int ADDR_W      = 10,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [31:0]       Instruction,
    input  logic [ADDR_W-1:0] Add,
    input  logic              Stall,
    input  logic              Flush,
    output logic              ValidID,
    output logic [ADDR_W-1:0] PC_ID,
    output logic [4:0]        Rd,
    output logic [4:0]        Rs1,
    output logic [4:0]        Rs2,
    output logic [2:0]        Funct3,
    output logic              Funct7b5,
    output logic [31:0]       Imm,
    output logic              RegWrite,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              ALUSrc,
    output logic              BranchOp,
    output logic              JumpOp,
    output logic              LuiAuipc,
    output logic              MulOp,
    output logic              Illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef DECODE_MUL_EN
    localparam logic [6:0] F7_MUL  = 7'b0000001;
`endif

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_DEPTH);

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    function automatic logic [31:0] build_imm(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [31:0] imm;
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    logic [6:0]  opcode_p0;
    logic [6:0]  funct7_p0;
    logic [2:0]  funct3_p0;
    logic [4:0]  rd_p0;
    logic        reg_write_p0;
    logic        mem_read_p0;
    logic        mem_write_p0;
    logic        alu_src_p0;
    logic        branch_op_p0;
    logic        jump_op_p0;
    logic        lui_auipc_p0;
    logic        illegal_p0;
    imm_fmt_e    fmt_p0;
    logic [31:0] imm_p0;
    logic [2:0]  squash_cnt;
`ifdef DECODE_MUL_EN
    logic        mul_op_p0;
    logic        mul_op_p1;
`endif

    assign opcode_p0 = Instruction[6:0];
    assign funct7_p0 = Instruction[31:25];
    assign funct3_p0 = Instruction[14:12];
    assign rd_p0     = Instruction[11:7];

    // Stage p0: combinational decode of the word arriving from fetch.
    always_comb begin
        reg_write_p0 = 1'b0;
        mem_read_p0  = 1'b0;
        mem_write_p0 = 1'b0;
        alu_src_p0   = 1'b0;
        branch_op_p0 = 1'b0;
        jump_op_p0   = 1'b0;
        lui_auipc_p0 = 1'b0;
        illegal_p0   = 1'b0;
        fmt_p0       = FMT_R;
`ifdef DECODE_MUL_EN
        mul_op_p0    = 1'b0;
`endif
        case (opcode_p0)
            OP_R: begin
                if (funct7_p0 == F7_BASE) begin
                    reg_write_p0 = 1'b1;
                end else if (funct7_p0 == F7_ALT &&
                             (funct3_p0 == 3'b000 || funct3_p0 == 3'b101)) begin
                    reg_write_p0 = 1'b1;
`ifdef DECODE_MUL_EN
                end else if (funct7_p0 == F7_MUL) begin
                    reg_write_p0 = 1'b1;
                    mul_op_p0    = 1'b1;
`endif
                end else begin
                    illegal_p0 = 1'b1;
                end
            end
            OP_I_ALU: begin
                reg_write_p0 = 1'b1;
                alu_src_p0   = 1'b1;
                fmt_p0       = FMT_I;
            end
            OP_LOAD: begin
                reg_write_p0 = 1'b1;
                mem_read_p0  = 1'b1;
                alu_src_p0   = 1'b1;
                fmt_p0       = FMT_I;
            end
            OP_STORE: begin
                mem_write_p0 = 1'b1;
                alu_src_p0   = 1'b1;
                fmt_p0       = FMT_S;
            end
            OP_BRANCH: begin
                branch_op_p0 = 1'b1;
                fmt_p0       = FMT_B;
            end
            OP_JAL: begin
                jump_op_p0   = 1'b1;
                reg_write_p0 = 1'b1;
                fmt_p0       = FMT_J;
            end
            OP_JALR: begin
                jump_op_p0   = 1'b1;
                reg_write_p0 = 1'b1;
                alu_src_p0   = 1'b1;
                fmt_p0       = FMT_I;
            end
            OP_LUI, OP_AUIPC: begin
                lui_auipc_p0 = 1'b1;
                reg_write_p0 = 1'b1;
                fmt_p0       = FMT_U;
            end
            default: illegal_p0 = 1'b1;
        endcase
        // x0 is hardwired, so a write to it is dropped here rather than in the register file.
        if (rd_p0 == 5'd0) begin
            reg_write_p0 = 1'b0;
        end
    end

    assign imm_p0 = build_imm(Instruction, fmt_p0);

    // Stage p1: IF/ID register. Reset > Flush > Stall > squash > load.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            ValidID    <= 1'b0;
            PC_ID      <= '0;
            Rd         <= '0;
            Rs1        <= '0;
            Rs2        <= '0;
            Funct3     <= '0;
            Funct7b5   <= 1'b0;
            Imm        <= '0;
            RegWrite   <= 1'b0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            ALUSrc     <= 1'b0;
            BranchOp   <= 1'b0;
            JumpOp     <= 1'b0;
            LuiAuipc   <= 1'b0;
            Illegal    <= 1'b0;
            squash_cnt <= '0;
        end else if (Flush) begin
            ValidID    <= 1'b0;
            RegWrite   <= 1'b0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            ALUSrc     <= 1'b0;
            BranchOp   <= 1'b0;
            JumpOp     <= 1'b0;
            LuiAuipc   <= 1'b0;
            Illegal    <= 1'b0;
            squash_cnt <= FLUSH_INIT;
        end else if (Stall) begin
            squash_cnt <= squash_cnt;
        end else if (squash_cnt != 3'd0) begin
            // Wrong-path word from fetch: drop it, data fields keep their last value.
            ValidID    <= 1'b0;
            RegWrite   <= 1'b0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            ALUSrc     <= 1'b0;
            BranchOp   <= 1'b0;
            JumpOp     <= 1'b0;
            LuiAuipc   <= 1'b0;
            Illegal    <= 1'b0;
            squash_cnt <= squash_cnt - 3'd1;
        end else begin
            ValidID    <= 1'b1;
            PC_ID      <= Add;
            Rd         <= rd_p0;
            Rs1        <= Instruction[19:15];
            Rs2        <= Instruction[24:20];
            Funct3     <= funct3_p0;
            Funct7b5   <= Instruction[30];
            Imm        <= imm_p0;
            RegWrite   <= reg_write_p0;
            MemRead    <= mem_read_p0;
            MemWrite   <= mem_write_p0;
            ALUSrc     <= alu_src_p0;
            BranchOp   <= branch_op_p0;
            JumpOp     <= jump_op_p0;
            LuiAuipc   <= lui_auipc_p0;
            Illegal    <= illegal_p0;
        end
    end

`ifdef DECODE_MUL_EN
    always_ff @(posedge clk) begin
        if (!Reset || Flush) begin
            mul_op_p1 <= 1'b0;
        end else if (!Stall) begin
            mul_op_p1 <= (squash_cnt == 3'd0) ? mul_op_p0 : 1'b0;
        end
    end
    assign MulOp = mul_op_p1;
`else
    assign MulOp = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, hand-written pipeline sequences,
// and randomized traffic against a behavioural reference model.
module tb_decode_stage;
    localparam int ADDR_W      = 10;
    localparam int FLUSH_DEPTH = 2;
`ifdef DECODE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              Reset = 1'b0;
    logic [31:0]       Instruction = '0;
    logic [ADDR_W-1:0] Add = '0;
    logic              Stall = 1'b0;
    logic              Flush = 1'b0;
    logic              ValidID;
    logic [ADDR_W-1:0] PC_ID;
    logic [4:0]        Rd, Rs1, Rs2;
    logic [2:0]        Funct3;
    logic              Funct7b5;
    logic [31:0]       Imm;
    logic              RegWrite, MemRead, MemWrite, ALUSrc, BranchOp, JumpOp, LuiAuipc;
    logic              MulOp, Illegal;

    decode_stage #(.ADDR_W(ADDR_W), .FLUSH_DEPTH(FLUSH_DEPTH)) dut (
        .clk(clk), .Reset(Reset), .Instruction(Instruction), .Add(Add),
        .Stall(Stall), .Flush(Flush), .ValidID(ValidID), .PC_ID(PC_ID),
        .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Funct3(Funct3), .Funct7b5(Funct7b5),
        .Imm(Imm), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .ALUSrc(ALUSrc), .BranchOp(BranchOp), .JumpOp(JumpOp), .LuiAuipc(LuiAuipc),
        .MulOp(MulOp), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    // ctl bit order: {RegWrite, MemRead, MemWrite, ALUSrc, BranchOp, JumpOp, LuiAuipc}
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] pc;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [2:0]        f3;
        logic              f7b5;
        logic [31:0]       imm;
        logic [6:0]        ctl;
        logic              mul;
        logic              ill;
    } out_t;

    typedef struct {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] add;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [2:0]        f3;
        logic              f7b5;
        logic [31:0]       imm;
        logic [6:0]        ctl;
        logic              mul;
        logic              ill;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    out_t mdl;
    int   sq = 0;
    bit   fchk = 1'b1;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    function automatic out_t dut_out();
        out_t o;
        o.valid = ValidID;  o.pc = PC_ID;  o.rd = Rd;  o.rs1 = Rs1;  o.rs2 = Rs2;
        o.f3 = Funct3;  o.f7b5 = Funct7b5;  o.imm = Imm;
        o.ctl = {RegWrite, MemRead, MemWrite, ALUSrc, BranchOp, JumpOp, LuiAuipc};
        o.mul = MulOp;  o.ill = Illegal;
        return o;
    endfunction

    // Reference decoder: immediates from the signed field values the ISA defines.
    function automatic out_t ref_decode(input logic [31:0] i, input logic [ADDR_W-1:0] pc);
        out_t o;
        logic signed [11:0] im_i, im_s;
        logic signed [12:0] im_b;
        logic signed [20:0] im_j;
        int   simm;
        bit   rw, mr, mw, as, br, jp, lu, mu, bad;
        rw = 0; mr = 0; mw = 0; as = 0; br = 0; jp = 0; lu = 0; mu = 0; bad = 0;
        im_i = i[31:20];
        im_s = {i[31:25], i[11:7]};
        im_b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        im_j = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        simm = 0;
        case (i[6:0])
            7'h33: begin
                if (i[31:25] == 7'h00 || (i[31:25] == 7'h20 && (i[14:12] == 3'd0 || i[14:12] == 3'd5))) rw = 1;
                else if (MUL_EN && i[31:25] == 7'h01) begin rw = 1; mu = 1; end
                else bad = 1;
            end
            7'h13: begin rw = 1; as = 1; simm = im_i; end
            7'h03: begin rw = 1; mr = 1; as = 1; simm = im_i; end
            7'h23: begin mw = 1; as = 1; simm = im_s; end
            7'h63: begin br = 1; simm = im_b; end
            7'h6F: begin jp = 1; rw = 1; simm = im_j; end
            7'h67: begin jp = 1; rw = 1; as = 1; simm = im_i; end
            7'h37, 7'h17: begin lu = 1; rw = 1; simm = int'(i[31:12]) * 4096; end
            default: bad = 1;
        endcase
        if (i[11:7] == 5'd0) rw = 0;
        o.valid = 1'b1;  o.pc = pc;  o.rd = i[11:7];  o.rs1 = i[19:15];  o.rs2 = i[24:20];
        o.f3 = i[14:12];  o.f7b5 = i[30];  o.imm = simm;
        o.ctl = {rw, mr, mw, as, br, jp, lu};
        o.mul = mu;  o.ill = bad;
        return o;
    endfunction

    task automatic compare(input string tag);
        out_t a;
        a = dut_out();
        check({tag, ".ValidID"}, 32'(a.valid), 32'(mdl.valid));
        check({tag, ".ctl"}, 32'(a.ctl), 32'(mdl.ctl));
        check({tag, ".MulOp"}, 32'(a.mul), 32'(mdl.mul));
        check({tag, ".Illegal"}, 32'(a.ill), 32'(mdl.ill));
        if (fchk) begin
            check({tag, ".PC_ID"}, 32'(a.pc), 32'(mdl.pc));
            check({tag, ".Rd"}, 32'(a.rd), 32'(mdl.rd));
            check({tag, ".Rs1"}, 32'(a.rs1), 32'(mdl.rs1));
            check({tag, ".Rs2"}, 32'(a.rs2), 32'(mdl.rs2));
            check({tag, ".Funct3"}, 32'(a.f3), 32'(mdl.f3));
            check({tag, ".Funct7b5"}, 32'(a.f7b5), 32'(mdl.f7b5));
            check({tag, ".Imm"}, a.imm, mdl.imm);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        if (!Reset) begin
            mdl = '0; sq = 0; fchk = 1'b1;
        end else if (Flush) begin
            mdl.valid = 0; mdl.ctl = '0; mdl.mul = 0; mdl.ill = 0; sq = FLUSH_DEPTH; fchk = 1'b0;
        end else if (Stall) begin
            sq = sq;
        end else if (sq > 0) begin
            mdl.valid = 0; mdl.ctl = '0; mdl.mul = 0; mdl.ill = 0; sq--; fchk = 1'b0;
        end else begin
            mdl = ref_decode(Instruction, Add); fchk = 1'b1;
        end
        #1;
        compare(tag);
    endtask

    task automatic add_vec(input logic [31:0] instr, input logic [ADDR_W-1:0] add,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [2:0] f3, input logic f7b5, input logic [31:0] imm,
                           input logic [6:0] ctl, input logic mul, input logic ill);
        vec_t v;
        v.instr = instr; v.add = add; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3;
        v.f7b5 = f7b5; v.imm = imm; v.ctl = ctl; v.mul = mul; v.ill = ill;
        tbl.push_back(v);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        r = $urandom();
        k = $urandom_range(0, 10);
        case (k)
            0: r[6:0] = 7'h33;
            1: r[6:0] = 7'h13;
            2: r[6:0] = 7'h03;
            3: r[6:0] = 7'h23;
            4: r[6:0] = 7'h63;
            5: r[6:0] = 7'h6F;
            6: r[6:0] = 7'h67;
            7: r[6:0] = 7'h37;
            8: r[6:0] = 7'h17;
            9: r = r;
            default: begin
                r[6:0] = 7'h33;
                k = $urandom_range(0, 3);
                if (k == 0) r[31:25] = 7'h00;
                else if (k == 1) r[31:25] = 7'h20;
                else if (k == 2) r[31:25] = 7'h01;
            end
        endcase
        if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
        return r;
    endfunction

    initial begin
        //       instr          add      rd  rs1 rs2 f3 f7b5 imm            ctl          mul ill
        add_vec(32'h00A00093, 10'h004,  1,  0, 10, 0, 0, 32'd10,       7'b1001000, 0, 0);
        add_vec(32'hFE0008E3, 10'h040, 17,  0,  0, 0, 1, 32'hFFFFFFF0, 7'b0000100, 0, 0);
        add_vec(32'h00000000, 10'h008,  0,  0,  0, 0, 0, 32'h0,        7'b0000000, 0, 1);
        add_vec(32'h0000007F, 10'h00C,  0,  0,  0, 0, 0, 32'h0,        7'b0000000, 0, 1);
        add_vec(32'h002081B3, 10'h010,  3,  1,  2, 0, 0, 32'h0,        7'b1000000, 0, 0);
        add_vec(32'h402081B3, 10'h014,  3,  1,  2, 0, 1, 32'h0,        7'b1000000, 0, 0);
        add_vec(32'h402091B3, 10'h018,  3,  1,  2, 1, 1, 32'h0,        7'b0000000, 0, 1);
        add_vec(32'h00812283, 10'h01C,  5,  2,  8, 2, 0, 32'd8,        7'b1101000, 0, 0);
        add_vec(32'hFE512E23, 10'h020, 28,  2,  5, 2, 1, 32'hFFFFFFFC, 7'b0011000, 0, 0);
        add_vec(32'hFFDFF0EF, 10'h024,  1, 31, 29, 7, 1, 32'hFFFFFFFC, 7'b1000010, 0, 0);
        add_vec(32'h00008067, 10'h028,  0,  1,  0, 0, 0, 32'h0,        7'b0001010, 0, 0);
        add_vec(32'h123453B7, 10'h02C,  7,  8,  3, 5, 0, 32'h12345000, 7'b1000001, 0, 0);
        add_vec(32'hFFFFF417, 10'h030,  8, 31, 31, 7, 1, 32'hFFFFF000, 7'b1000001, 0, 0);
        add_vec(32'hFFF0E093, 10'h034,  1,  1, 31, 6, 1, 32'hFFFFFFFF, 7'b1001000, 0, 0);
        add_vec(32'h0000000F, 10'h038,  0,  0,  0, 0, 0, 32'h0,        7'b0000000, 0, 1);
        add_vec(32'h00A00091, 10'h03C,  1,  0, 10, 0, 0, 32'h0,        7'b0000000, 0, 1);
`ifdef DECODE_MUL_EN
        add_vec(32'h02208033, 10'h044,  0,  1,  2, 0, 0, 32'h0,        7'b0000000, 1, 0);
`else
        add_vec(32'h02208033, 10'h044,  0,  1,  2, 0, 0, 32'h0,        7'b0000000, 0, 1);
`endif

        // Reset held two cycles, then release.
        Reset = 1'b0; Instruction = 32'h00A00093; Add = 10'h000;
        step("rst0");
        step("rst1");
        check("rst.ValidID", 32'(ValidID), 32'd0);
        check("rst.Imm", Imm, 32'd0);
        check("rst.RegWrite", 32'(RegWrite), 32'd0);
        Reset = 1'b1;
        step("rel");
        check("rel.ValidID", 32'(ValidID), 32'd1);
        check("rel.Rd", 32'(Rd), 32'd1);
        check("rel.Imm", Imm, 32'd10);
        check("rel.RegWrite", 32'(RegWrite), 32'd1);
        check("rel.ALUSrc", 32'(ALUSrc), 32'd1);

        foreach (tbl[n]) begin
            Instruction = tbl[n].instr; Add = tbl[n].add;
            step("tbl");
            check($sformatf("tbl%0d.ValidID", n), 32'(ValidID), 32'd1);
            check($sformatf("tbl%0d.PC_ID", n), 32'(PC_ID), 32'(tbl[n].add));
            check($sformatf("tbl%0d.Rd", n), 32'(Rd), 32'(tbl[n].rd));
            check($sformatf("tbl%0d.Rs1", n), 32'(Rs1), 32'(tbl[n].rs1));
            check($sformatf("tbl%0d.Rs2", n), 32'(Rs2), 32'(tbl[n].rs2));
            check($sformatf("tbl%0d.Funct3", n), 32'(Funct3), 32'(tbl[n].f3));
            check($sformatf("tbl%0d.Funct7b5", n), 32'(Funct7b5), 32'(tbl[n].f7b5));
            check($sformatf("tbl%0d.Imm", n), Imm, tbl[n].imm);
            check($sformatf("tbl%0d.ctl", n), 32'({RegWrite, MemRead, MemWrite, ALUSrc, BranchOp, JumpOp, LuiAuipc}), 32'(tbl[n].ctl));
            check($sformatf("tbl%0d.MulOp", n), 32'(MulOp), 32'(tbl[n].mul));
            check($sformatf("tbl%0d.Illegal", n), 32'(Illegal), 32'(tbl[n].ill));
        end

        // Flush then three fetched words: 0 at the flush edge, then 0,0,1.
        Instruction = 32'h00A00093; Flush = 1'b1;
        step("fl");
        check("fl.ValidID", 32'(ValidID), 32'd0);
        check("fl.RegWrite", 32'(RegWrite), 32'd0);
        Flush = 1'b0;
        for (int w = 0; w < 3; w++) begin
            Add = 10'(w * 4);
            step("flw");
            check($sformatf("flw%0d.ValidID", w), 32'(ValidID), (w == 2) ? 32'd1 : 32'd0);
            check($sformatf("flw%0d.RegWrite", w), 32'(RegWrite), (w == 2) ? 32'd1 : 32'd0);
        end

        // Stall holds a loaded lw while the fetched word changes.
        Instruction = 32'h00812283; Add = 10'h100;
        step("ld");
        Stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            Instruction = $urandom(); Add = 10'($urandom());
            step("st");
            check($sformatf("st%0d.ValidID", s), 32'(ValidID), 32'd1);
            check($sformatf("st%0d.Rd", s), 32'(Rd), 32'd5);
            check($sformatf("st%0d.Imm", s), Imm, 32'd8);
            check($sformatf("st%0d.MemRead", s), 32'(MemRead), 32'd1);
            check($sformatf("st%0d.PC_ID", s), 32'(PC_ID), 32'h100);
        end
        Flush = 1'b1;
        step("stfl");
        check("stfl.ValidID", 32'(ValidID), 32'd0);
        Flush = 1'b0;
        step("sthold0");
        step("sthold1");
        Stall = 1'b0; Instruction = 32'h00A00093;
        for (int w = 0; w < 3; w++) begin
            step("stsq");
            check($sformatf("stsq%0d.ValidID", w), 32'(ValidID), (w == 2) ? 32'd1 : 32'd0);
        end

        // Flush during a squash reloads the counter.
        Flush = 1'b1; step("rl0");
        Flush = 1'b0; step("rl1");
        Flush = 1'b1; step("rl2");
        Flush = 1'b0;
        for (int w = 0; w < 3; w++) begin
            step("rlsq");
            check($sformatf("rlsq%0d.ValidID", w), 32'(ValidID), (w == 2) ? 32'd1 : 32'd0);
        end

        // Reset mid-squash clears the counter.
        Flush = 1'b1; step("mr0");
        Flush = 1'b0; Reset = 1'b0; step("mr1");
        check("mr1.ValidID", 32'(ValidID), 32'd0);
        Reset = 1'b1; step("mr2");
        check("mr2.ValidID", 32'(ValidID), 32'd1);

        for (int c = 0; c < 600; c++) begin
            Reset       = ($urandom_range(0, 49) != 0);
            Flush       = ($urandom_range(0, 9) == 0);
            Stall       = ($urandom_range(0, 5) == 0);
            Instruction = rand_instr();
            Add         = 10'($urandom());
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
